// File: rtl/roce_stack_pkg.sv
// Shared types and constants for the RoCE stack address translator.
// The response struct packs to the 116-bit response channel layout.
package roce_stack_pkg;

  localparam int PADDR_W            = 64;
  localparam int REM_W              = 28;
  localparam int RSV_W              = 23;
  localparam int RESP_W             = RSV_W + 1 + REM_W + PADDR_W;
  localparam int CNT_W              = 32;
  localparam int DEFAULT_PAGE_SHIFT = 21;

  typedef struct packed {
    logic [RSV_W-1:0]   reserved;
    logic               hit;
    logic [REM_W-1:0]   remaining;
    logic [PADDR_W-1:0] paddr;
  } roce_xlat_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } xlat_state_t;

endpackage

// File: rtl/roce_stack_xlat_table.sv
// Fully-associative page table: entry storage, write/flush port and a
// match vector registered during the lookup cycle.
module roce_stack_xlat_table
  import roce_stack_pkg::*;
#(
  parameter int N_ENTRIES  = 16,
  parameter int PAGE_SHIFT = DEFAULT_PAGE_SHIFT
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_cfg_wr_en,
  input  logic [$clog2(N_ENTRIES)-1:0]  i_cfg_idx,
  input  logic [PADDR_W-PAGE_SHIFT-1:0] i_cfg_vpn,
  input  logic [PADDR_W-PAGE_SHIFT-1:0] i_cfg_ppn,
  input  logic                          i_cfg_entry_valid,
  input  logic                          i_cfg_flush,
  input  logic                          i_lookup_en,
  input  logic [PADDR_W-PAGE_SHIFT-1:0] i_lookup_vpn,
  input  logic [$clog2(N_ENTRIES)-1:0]  i_rd_idx,
  output logic [N_ENTRIES-1:0]          o_match,
  output logic [PADDR_W-PAGE_SHIFT-1:0] o_rd_ppn
);

  localparam int PN_W = PADDR_W - PAGE_SHIFT;

  logic [PN_W-1:0]      r_vpn [N_ENTRIES];
  logic [PN_W-1:0]      r_ppn [N_ENTRIES];
  logic [N_ENTRIES-1:0] r_valid;
  logic [N_ENTRIES-1:0] r_match;
  logic [N_ENTRIES-1:0] w_match;

  always_ff @(posedge i_clk) begin
    if (i_cfg_wr_en) begin
      r_vpn[i_cfg_idx] <= i_cfg_vpn;
      r_ppn[i_cfg_idx] <= i_cfg_ppn;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
      // A write on the same edge as a flush wins, so flush-then-write semantics hold.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_valid[gi] <= 1'b0;
        end else if (i_cfg_wr_en && (i_cfg_idx == gi[$clog2(N_ENTRIES)-1:0])) begin
          r_valid[gi] <= i_cfg_entry_valid;
        end else if (i_cfg_flush) begin
          r_valid[gi] <= 1'b0;
        end
      end

      assign w_match[gi] = r_valid[gi] && (r_vpn[gi] == i_lookup_vpn);
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_match <= '0;
    end else if (i_lookup_en) begin
      r_match <= w_match;
    end
  end

  assign o_match  = r_match;
  assign o_rd_ppn = r_ppn[i_rd_idx];

endmodule

// File: rtl/roce_stack_addr_translator.sv
// Virtual-to-physical address translator for one RoCE request channel:
// request FSM, priority encoder, response formatting and hit/miss counters.
module roce_stack_addr_translator
  import roce_stack_pkg::*;
#(
  parameter int N_ENTRIES  = 16,
  parameter int PAGE_SHIFT = DEFAULT_PAGE_SHIFT
) (
  input  logic                          axis_aclk_i,
  input  logic                          aresetn_i,
  input  logic                          req_addr_valid_i,
  output logic                          req_addr_ready_o,
  input  logic [PADDR_W-1:0]            req_addr_vaddr_i,
  output logic                          resp_addr_valid_o,
  input  logic                          resp_addr_ready_i,
  output logic [RESP_W-1:0]             resp_addr_data_o,
  input  logic                          cfg_wr_en_i,
  input  logic [$clog2(N_ENTRIES)-1:0]  cfg_idx_i,
  input  logic [PADDR_W-PAGE_SHIFT-1:0] cfg_vpn_i,
  input  logic [PADDR_W-PAGE_SHIFT-1:0] cfg_ppn_i,
  input  logic                          cfg_entry_valid_i,
  input  logic                          cfg_flush_i,
  output logic [CNT_W-1:0]              hit_cnt_o,
  output logic [CNT_W-1:0]              miss_cnt_o
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int PN_W  = PADDR_W - PAGE_SHIFT;
  localparam logic [REM_W-1:0] PAGE_BYTES = REM_W'(1) << PAGE_SHIFT;

  xlat_state_t          r_state;
  xlat_state_t          w_state_next;
  logic                 r_rst_done;
  logic [PADDR_W-1:0]   r_vaddr;
  logic                 r_resp_held;
  roce_xlat_resp_t      r_resp_hold;
  logic [CNT_W-1:0]     r_hit_cnt;
  logic [CNT_W-1:0]     r_miss_cnt;

  logic                 w_req_ready;
  logic                 w_accept;
  logic                 w_resp_valid;
  logic                 w_resp_hs;
  logic [N_ENTRIES-1:0] w_match;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_any_hit;
  logic [PN_W-1:0]      w_ppn;
  logic [PAGE_SHIFT-1:0] w_offset;
  roce_xlat_resp_t      w_resp;
  roce_xlat_resp_t      w_resp_out;

  roce_stack_xlat_table #(
    .N_ENTRIES  (N_ENTRIES),
    .PAGE_SHIFT (PAGE_SHIFT)
  ) u_table (
    .i_clk             (axis_aclk_i),
    .i_rst_n           (aresetn_i),
    .i_cfg_wr_en       (cfg_wr_en_i),
    .i_cfg_idx         (cfg_idx_i),
    .i_cfg_vpn         (cfg_vpn_i),
    .i_cfg_ppn         (cfg_ppn_i),
    .i_cfg_entry_valid (cfg_entry_valid_i),
    .i_cfg_flush       (cfg_flush_i),
    .i_lookup_en       (r_state == ST_LOOKUP),
    .i_lookup_vpn      (r_vaddr[PADDR_W-1:PAGE_SHIFT]),
    .i_rd_idx          (w_hit_idx),
    .o_match           (w_match),
    .o_rd_ppn          (w_ppn)
  );

  // Ready stays low until the first clock edge after reset release.
  always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_state    <= ST_IDLE;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rst_done <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = r_rst_done;
        if (req_addr_valid_i && r_rst_done) w_state_next = ST_LOOKUP;
      end
      ST_LOOKUP: w_state_next = ST_RESP;
      ST_RESP: begin
        w_resp_valid = 1'b1;
        if (resp_addr_ready_i) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_accept  = w_req_ready && req_addr_valid_i;
  assign w_resp_hs = w_resp_valid && resp_addr_ready_i;

  always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_vaddr <= '0;
    end else if (w_accept) begin
      r_vaddr <= req_addr_vaddr_i;
    end
  end

  // Lowest matching index wins.
  always_comb begin
    w_hit_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_idx = IDX_W'(i);
    end
  end

  assign w_any_hit = |w_match;
  assign w_offset  = r_vaddr[PAGE_SHIFT-1:0];

  always_comb begin
    w_resp           = '0;
    w_resp.hit       = w_any_hit;
    w_resp.remaining = PAGE_BYTES - REM_W'(w_offset);
    w_resp.paddr     = w_any_hit ? {w_ppn, w_offset} : r_vaddr;
  end

  // Snapshot the response after its first cycle so later table writes cannot disturb it.
  always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_resp_held <= 1'b0;
      r_resp_hold <= '0;
    end else if (w_resp_valid && !w_resp_hs) begin
      r_resp_held <= 1'b1;
      if (!r_resp_held) r_resp_hold <= w_resp;
    end else begin
      r_resp_held <= 1'b0;
    end
  end

  assign w_resp_out = r_resp_held ? r_resp_hold : w_resp;

  always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_resp_hs) begin
      if (w_resp_out.hit) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end else if (r_miss_cnt != '1) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  assign req_addr_ready_o  = w_req_ready;
  assign resp_addr_valid_o = w_resp_valid;
  assign resp_addr_data_o  = w_resp_valid ? w_resp_out : '0;
  assign hit_cnt_o         = r_hit_cnt;
  assign miss_cnt_o        = r_miss_cnt;

endmodule
